aes_top: RTL and testbench
==========================

// Module: aes_top
// PURPOSE
//  Iterative AES-128 encryption core (FIPS-197), one round per clock.
//  Captures a 128-bit plaintext and 128-bit cipher key, runs the initial
//  AddRoundKey plus 10 rounds, and presents the ciphertext on a held register.
//  Free-running: no start/valid handshake; it re-samples inputs every 11 cycles.
//  Top-level crypto datapath; key schedule is expanded on the fly, not stored.
// PARAMETERS
//  none (AES-128 only: Nk=4, Nr=10 fixed)
// PORTS
//  clk       in   1    system clock, all state updates on rising edge
//  rst       in   1    asynchronous, active-high reset
//  data_in   in   128  plaintext; [127:120] = byte 0 (state s[0][0]), column-major
//  key       in   128  cipher key; [127:120] = key byte 0
//  data_out  out  128  ciphertext, same byte order; registered, held between updates
// BEHAVIOUR
//  - One clock (clk); rst is async active-high. While rst=1: round counter=0,
//    state=0, round key=0, data_out=128'h0.
//  - Round counter rnd cycles 0..10, then wraps to 0.
//  - rnd=0 (capture edge): state <= data_in ^ key; rk <= key; rnd <= 1.
//    Inputs are sampled only on this edge; changes at other times are ignored
//    until the next capture.
//  - rnd=1..9: next rk = KeyExpand(rk, Rcon[rnd]);
//    state <= MixColumns(ShiftRows(SubBytes(state))) ^ next rk.
//  - rnd=10: final round without MixColumns; data_out <= result; rnd <= 0.
//    state and rk registers are don't-care after this edge.
//  - KeyExpand: w0'=w0^SubWord(RotWord(w3))^{Rcon,24'h0}; w1'=w1^w0';
//    w2'=w2^w1'; w3'=w3^w2' (w0 = rk[127:96]).
//  - Rcon = 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.
//  - SubBytes/SubWord use the standard forward S-box (combinational LUT or
//    GF(2^8) inverse+affine); 16 state + 4 key S-boxes in parallel.
//  - MixColumns over GF(2^8), poly 0x11b; xtime(b) = (b<<1) ^ (b[7] ? 8'h1b : 0).
//  - Timing: capture edge at cycle 0; data_out updates 10 edges later (cycle 10);
//    next capture on cycle 11. Throughput: one block per 11 cycles.
//  - data_out changes only on rnd=10 edges, stable for 11 cycles in between.
//  - First valid data_out: 11th rising edge after rst deasserts.
//  - rst asserted mid-operation: aborts immediately, all registers cleared;
//    processing restarts with a capture on the first edge after deassertion.
//  - No decryption, no key-length options, no output valid strobe.
// TESTING
//  1 Reset: rst=1 with random inputs -> data_out=0 throughout; after release
//    data_out stays 0 until the first rnd=10 edge.
//  2 Zero vector: data_in=0, key=0 -> data_out=66e94bd4ef8a2c3b884cfa59ca342b2e.
//  3 FIPS-197 App.B: data_in=3243f6a8885a308d313198a2e0370734,
//    key=2b7e151628aed2a6abf7158809cf4f3c -> data_out=3925841d02dc09fbdc118597196a0b32;
//    check intermediate state after round 1 = a49c7ff2689f352b6b5bea43026a5049.
//  4 FIPS-197 C.1: data_in=00112233445566778899aabbccddeeff,
//    key=000102030405060708090a0b0c0d0e0f -> 69c4e0d86a7b0430d8cdb78070b4c55a.
//  5 Input change mid-block (as in 3, switch to vector 4 at rnd=5) -> current
//    output still 3925...0b32; next output 69c4...c55a after the following capture.
//  6 rst pulse at rnd=6 -> data_out=0 immediately; correct ciphertext 11 edges
//    after release; latency measured as exactly 10 edges capture-to-output.

Source files
------------

// File: rtl/aes_top.sv
// Iterative AES-128 encryptor: one round per clock, 11-cycle free-running frame.
// Key schedule is expanded on the fly alongside the state; data_out is held between blocks.
module aes_top (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] data_in,
  input  logic [127:0] key,
  output logic [127:0] data_out
);

  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] dout_q, dout_d;

  logic [127:0] sb, sr, mc, rk_next;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (a^254, zero maps to zero) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Byte index r + 4c is row r, column c; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_column(s[127:96]), mix_column(s[95:64]),
            mix_column(s[63:32]), mix_column(s[31:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  always_comb begin
    sb      = sub_bytes(state_q);
    sr      = shift_rows(sb);
    mc      = mix_columns(sr);
    rk_next = key_expand(rk_q, rcon(rnd_q));

    rnd_d   = rnd_q;
    state_d = state_q;
    rk_d    = rk_q;
    dout_d  = dout_q;

    if (rnd_q == 4'd0) begin
      state_d = data_in ^ key;
      rk_d    = key;
      rnd_d   = 4'd1;
    end else if (rnd_q >= 4'd10) begin
      // Final round skips MixColumns; state/rk are left as-is until the next capture.
      dout_d  = sr ^ rk_next;
      rnd_d   = 4'd0;
    end else begin
      state_d = mc ^ rk_next;
      rk_d    = rk_next;
      rnd_d   = rnd_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rnd_q   <= 4'd0;
      state_q <= '0;
      rk_q    <= '0;
      dout_q  <= '0;
    end else begin
      rnd_q   <= rnd_d;
      state_q <= state_d;
      rk_q    <= rk_d;
      dout_q  <= dout_d;
    end
  end

  assign data_out = dout_q;

endmodule

// File: tb/tb_aes_top.sv
// Bench for aes_top: known-answer vectors applied as 11-cycle frames, plus
// reset, mid-block input change and mid-block reset sequences.
module tb_aes_top;

  logic         clk;
  logic         rst;
  logic [127:0] data_in;
  logic [127:0] key;
  logic [127:0] data_out;

  aes_top dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .key      (key),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
    logic         has_r1;
    logic [127:0] r1;
    int           sw_at;
    logic [127:0] sw_pt;
    logic [127:0] sw_key;
  } vec_t;

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] R1_B  = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  vec_t         vecs[5];
  logic [127:0] exp_q[$];
  logic [127:0] last_exp;
  logic [127:0] exp_v;
  int           n_tests;
  int           n_fail;
  int           lat;
  bit           seen;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One 11-edge frame: capture on the first edge, output on the eleventh.
  task automatic run_block(input vec_t v);
    data_in = v.pt;
    key     = v.key;
    exp_q.push_back(v.ct);
    for (int t = 1; t <= 11; t++) begin
      tick();
      if (v.has_r1 && t == 2) check("round1_state", dut.state_q, v.r1);
      if (v.sw_at != 0 && t == v.sw_at) begin
        data_in = v.sw_pt;
        key     = v.sw_key;
      end
      if (t < 11) begin
        check("hold", data_out, last_exp);
      end else if (exp_q.size() == 0) begin
        check("queue_empty", 128'h1, 128'h0);
      end else begin
        exp_v = exp_q.pop_front();
        check("ciphertext", data_out, exp_v);
        last_exp = exp_v;
      end
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    last_exp = '0;
    rst      = 1'b1;
    data_in  = '0;
    key      = '0;

    vecs[0] = '{pt: '0,   key: '0,    ct: CT_0, has_r1: 1'b0, r1: '0,   sw_at: 0, sw_pt: '0,   sw_key: '0};
    vecs[1] = '{pt: PT_B, key: KEY_B, ct: CT_B, has_r1: 1'b1, r1: R1_B, sw_at: 0, sw_pt: '0,   sw_key: '0};
    vecs[2] = '{pt: PT_C, key: KEY_C, ct: CT_C, has_r1: 1'b0, r1: '0,   sw_at: 0, sw_pt: '0,   sw_key: '0};
    vecs[3] = '{pt: PT_B, key: KEY_B, ct: CT_B, has_r1: 1'b1, r1: R1_B, sw_at: 5, sw_pt: PT_C, sw_key: KEY_C};
    vecs[4] = '{pt: PT_C, key: KEY_C, ct: CT_C, has_r1: 1'b0, r1: '0,   sw_at: 0, sw_pt: '0,   sw_key: '0};

    // Reset held with random inputs: output must stay zero.
    for (int i = 0; i < 5; i++) begin
      data_in = {$urandom, $urandom, $urandom, $urandom};
      key     = {$urandom, $urandom, $urandom, $urandom};
      tick();
      check("reset_out", data_out, 128'h0);
    end
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_block(vecs[i]);

    // Reset pulse at rnd=6: output clears asynchronously, frame restarts after release.
    data_in = PT_B;
    key     = KEY_B;
    for (int t = 1; t <= 6; t++) begin
      tick();
      check("hold_pre_rst", data_out, last_exp);
    end
    rst = 1'b1;
    #1;
    check("rst_async_clear", data_out, 128'h0);
    tick();
    check("rst_held", data_out, 128'h0);
    rst      = 1'b0;
    last_exp = '0;
    data_in  = PT_C;
    key      = KEY_C;
    exp_q.push_back(CT_C);
    lat  = 0;
    seen = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (!seen && data_out !== 128'h0) begin
        lat  = t;
        seen = 1'b1;
        break;
      end
    end
    check("latency_edges_after_release", 128'(lat), 128'd11);
    exp_v = exp_q.pop_front();
    check("ciphertext_after_rst", data_out, exp_v);
    last_exp = exp_v;

    // One more frame to confirm steady-state resumes after the reset.
    run_block(vecs[1]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
